// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one SRAM command interface among NUM_PORTS requestors. Any port may
//   issue reads or writes. Arbitration is round-robin (ARB_MODE=0) or
//   fixed-priority with port 0 highest (ARB_MODE=1). Read responses are routed
//   back to the issuing port in order through a tag FIFO of issuing-port indices.
//
// Ports
//   sram_clock, reset          : sole clock (rising edge), async active-high reset
//   req_valid/write/addr/data/mask : packed per-port requests (port p at slice p)
//   req_ready                  : combinational one-hot grant (or zero)
//   rsp_valid, rsp_data        : one-cycle per-port read strobe, shared read data
//   sram_addr_valid/addr/data_in/write_mask, sram_ready : command register + handshake
//   sram_data_out, sram_data_out_valid : read return from controller (no backpressure)
//   state                      : {busy, rd_full, err, last_grant}
//   err                        : sticky, read data arrived with no outstanding read
module sram_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int RD_DEPTH   = 4,
  parameter int ARB_MODE   = 0,
  localparam int PW = $clog2(NUM_PORTS),
  localparam int TW = $clog2(RD_DEPTH),
  localparam int CW = TW + 1
) (
  input  logic                             sram_clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_mask,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             sram_addr_valid,
  input  logic                             sram_ready,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  output logic [DATA_WIDTH-1:0]            sram_data_in,
  output logic [MASK_WIDTH-1:0]            sram_write_mask,
  input  logic [DATA_WIDTH-1:0]            sram_data_out,
  input  logic                             sram_data_out_valid,
  output logic [PW+2:0]                    state,
  output logic                             err
);

  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [MASK_WIDTH-1:0] cmd_mask_q, cmd_mask_d;
  logic [PW-1:0]         last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;
  logic [PW-1:0]         tag_mem_q [RD_DEPTH];
  logic [TW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         tag_cnt_q, tag_cnt_d;

  logic                  slot_free;
  logic [NUM_PORTS-1:0]  eligible;
  logic                  gnt_found;
  logic [PW-1:0]         gnt_idx;
  int                    cand;
  logic                  xfer, gnt_write, push, pop, issue;
  logic [MASK_WIDTH-1:0] gnt_mask;

  assign slot_free = !cmd_valid_q || sram_ready;

  // Reads are held off once every tag slot is in use, so a push never overflows.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_valid[p] && (req_write[p] || (tag_cnt_q < CW'(RD_DEPTH)));
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 1) cand = i;
      else cand = (int'(last_grant_q) + 1 + i) % NUM_PORTS;
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(cand);
      end
    end
  end

  // Grant is suppressed while reset is held so req_ready reads 0 immediately.
  always_comb begin
    req_ready = '0;
    if (gnt_found && slot_free && !reset) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer      = |req_ready;
  assign gnt_write = req_write[gnt_idx];
  assign gnt_mask  = req_mask[int'(gnt_idx)*MASK_WIDTH +: MASK_WIDTH];
  assign push      = xfer && !gnt_write;
  // A write with an empty mask is accepted but never reaches the SRAM.
  assign issue     = xfer && (!gnt_write || (gnt_mask != '0));
  assign pop       = sram_data_out_valid && (tag_cnt_q != '0);

  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    cmd_mask_d   = cmd_mask_q;
    last_grant_d = last_grant_q;
    if (slot_free) begin
      cmd_valid_d = issue;
      if (issue) begin
        cmd_addr_d = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_data_d = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        cmd_mask_d = gnt_write ? gnt_mask : '0;
      end
    end
    if (xfer) last_grant_d = gnt_idx;
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + TW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + TW'(1) : rd_ptr_q;
    tag_cnt_d   = tag_cnt_q;
    if (push && !pop) tag_cnt_d = tag_cnt_q + CW'(1);
    else if (pop && !push) tag_cnt_d = tag_cnt_q - CW'(1);
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
      rsp_data_d = sram_data_out;
    end
    err_d = err_q || (sram_data_out_valid && (tag_cnt_q == '0));
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      cmd_mask_q   <= '0;
      last_grant_q <= PW'(NUM_PORTS - 1);
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_cnt_q    <= '0;
      for (int i = 0; i < RD_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      cmd_mask_q   <= cmd_mask_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
      if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign sram_addr_valid = cmd_valid_q;
  assign sram_addr       = cmd_addr_q;
  assign sram_data_in    = cmd_data_q;
  assign sram_write_mask = cmd_mask_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign err             = err_q;
  assign state = {cmd_valid_q || (tag_cnt_q != '0), tag_cnt_q == CW'(RD_DEPTH), err_q, last_grant_q};

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req_valid, req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic [NP*MW-1:0] req_mask;
  logic             sram_ready, dv;
  logic [DW-1:0]    sram_data_out;

  logic [NP-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, sram_data_in;
  logic          sram_addr_valid, err;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_write_mask;
  logic [4:0]    state;

  logic [NP-1:0] fp_req_ready, fp_rsp_valid;
  logic [DW-1:0] fp_rsp_data, fp_data_in;
  logic          fp_addr_valid, fp_err;
  logic [AW-1:0] fp_addr;
  logic [MW-1:0] fp_mask;
  logic [4:0]    fp_state;

  int errors = 0;
  int checks = 0;
  int order[4] = '{2, 0, 3, 1};
  logic [DW-1:0] rd_dat[4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};

  sram_port_arbiter #(.ARB_MODE(0)) dut (
    .sram_clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
    .sram_data_out(sram_data_out), .sram_data_out_valid(dv),
    .state(state), .err(err)
  );

  sram_port_arbiter #(.ARB_MODE(1)) dut_fp (
    .sram_clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(fp_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(fp_rsp_valid), .rsp_data(fp_rsp_data),
    .sram_addr_valid(fp_addr_valid), .sram_ready(sram_ready), .sram_addr(fp_addr),
    .sram_data_in(fp_data_in), .sram_write_mask(fp_mask),
    .sram_data_out(sram_data_out), .sram_data_out_valid(dv),
    .state(fp_state), .err(fp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_write[p]           = w;
    req_addr[p*AW +: AW]   = a;
    req_data[p*DW +: DW]   = d;
    req_mask[p*MW +: MW]   = m;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; req_mask = '0;
    sram_ready = 1'b1; dv = 1'b0; sram_data_out = '0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_addr_valid", sram_addr_valid, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_mask", sram_write_mask, 0);
    chk("rst_state", state, 5'b00011);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // round-robin writes from all ports
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(32'h100 + p), DW'(32'hD0 + p), 4'hF);
    req_valid = 4'hF;
    settle;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", req_ready, 64'd1 << (k % 4));
      chk("fp_grant_all", fp_req_ready, 4'b0001);
      tick;
      chk("rr_addr", sram_addr, 64'h100 + (k % 4));
      chk("rr_data", sram_data_in, 64'hD0 + (k % 4));
      chk("rr_valid", sram_addr_valid, 1);
      chk("rr_mask", sram_write_mask, 4'hF);
    end
    req_valid = '0;
    settle;
    chk("idle_grant", req_ready, 0);
    tick;
    chk("idle_valid", sram_addr_valid, 0);

    // fixed priority: ports 1 and 3
    set_port(1, 1'b1, AW'(32'h11), DW'(32'h1111), 4'hF);
    set_port(3, 1'b1, AW'(32'h33), DW'(32'h3333), 4'hF);
    req_valid = 4'b1010;
    settle;
    chk("fp_p1_a", fp_req_ready, 4'b0010);
    tick;
    chk("fp_p1_b", fp_req_ready, 4'b0010);
    tick;
    req_valid = 4'b1000;
    settle;
    chk("fp_p3", fp_req_ready, 4'b1000);
    tick;
    req_valid = '0;
    settle;
    tick;
    chk("state_after_fp", state, 5'b00011);

    // backpressure
    sram_ready = 1'b0;
    set_port(2, 1'b1, AW'(32'h222), 32'hCAFE_0002, 4'h5);
    req_valid = 4'b0100;
    settle;
    chk("bp_first_grant", req_ready, 4'b0100);
    tick;
    set_port(2, 1'b1, AW'(32'h333), 32'hCAFE_0003, 4'h3);
    settle;
    for (int j = 0; j < 5; j++) begin
      chk("bp_ready_low", req_ready, 0);
      chk("bp_addr", sram_addr, 19'h222);
      chk("bp_data", sram_data_in, 32'hCAFE_0002);
      chk("bp_mask", sram_write_mask, 4'h5);
      chk("bp_valid", sram_addr_valid, 1);
      tick;
    end
    sram_ready = 1'b1;
    settle;
    chk("bp_resume", req_ready, 4'b0100);
    tick;
    chk("bp_next_addr", sram_addr, 19'h333);
    chk("bp_next_mask", sram_write_mask, 4'h3);

    // write with empty mask is accepted and dropped
    set_port(1, 1'b1, AW'(32'h777), 32'h0, 4'h0);
    req_valid = 4'b0010;
    settle;
    chk("drop_grant", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    chk("drop_no_cmd", sram_addr_valid, 0);
    chk("drop_state", state, 5'b00001);

    // in-order read responses
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(32'h40 + p), 32'h0, 4'hF);
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4) ? 4'(1 << order[c]) : 4'b0000;
      dv = (c >= 3);
      sram_data_out = (c >= 3) ? rd_dat[c-3] : '0;
      settle;
      if (c < 4) chk("rd_grant", req_ready, 64'd1 << order[c]);
      tick;
      if (c < 4) begin
        chk("rd_mask_zero", sram_write_mask, 0);
        chk("rd_addr", sram_addr, 64'h40 + order[c]);
      end
      if (c >= 3) begin
        chk("rsp_port", rsp_valid, 64'd1 << order[c-3]);
        chk("rsp_data", rsp_data, rd_dat[c-3]);
      end else begin
        chk("rsp_quiet", rsp_valid, 0);
      end
    end
    dv = 1'b0;
    req_valid = '0;
    settle;
    chk("rd_done_state", state, 5'b00001);

    // tag FIFO full stalls reads but not writes
    set_port(0, 1'b0, AW'(32'h50), 32'h0, 4'hF);
    req_valid = 4'b0001;
    settle;
    for (int k = 0; k < 4; k++) begin
      chk("full_rd_grant", req_ready, 4'b0001);
      tick;
    end
    chk("full_state", state, 5'b11000);
    chk("full_stall", req_ready, 0);
    set_port(1, 1'b1, AW'(32'h555), 32'h5555, 4'hF);
    req_valid = 4'b0011;
    settle;
    chk("full_wr_grant", req_ready, 4'b0010);
    tick;
    chk("full_wr_addr", sram_addr, 19'h555);
    chk("full_wr_mask", sram_write_mask, 4'hF);
    req_valid = 4'b0001;
    dv = 1'b1;
    sram_data_out = 32'h11;
    settle;
    chk("full_still_stall", req_ready, 0);
    tick;
    dv = 1'b0;
    chk("full_rsp", rsp_valid, 4'b0001);
    chk("full_rsp_data", rsp_data, 32'h11);
    settle;
    chk("full_freed", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      dv = 1'b1;
      sram_data_out = DW'(32'h20 + k);
      tick;
      chk("drain_rsp", rsp_valid, 4'b0001);
      chk("drain_data", rsp_data, 64'h20 + k);
    end
    dv = 1'b0;
    tick;
    chk("drain_quiet", rsp_valid, 0);
    chk("drain_state", state, 5'b00000);

    // response with nothing outstanding
    dv = 1'b1;
    sram_data_out = 32'hBAD;
    tick;
    dv = 1'b0;
    chk("err_set", err, 1);
    chk("err_no_rsp", rsp_valid, 0);
    chk("err_data_kept", rsp_data, 32'h23);
    chk("err_state", state, 5'b00100);

    // asynchronous reset mid-burst
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(32'h600 + p), DW'(32'hE0 + p), 4'hF);
    req_valid = 4'hF;
    settle;
    tick;
    tick;
    chk("burst_active", sram_addr_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_addr_valid", sram_addr_valid, 0);
    chk("arst_addr", sram_addr, 0);
    chk("arst_data", sram_data_in, 0);
    chk("arst_mask", sram_write_mask, 0);
    chk("arst_err", err, 0);
    chk("arst_state", state, 5'b00011);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
